// File: rtl/csr_file_pkg.sv
// Shared CSR definitions: implemented address map, mstatus bit positions and misa value.
package csr_file_pkg;

    typedef enum logic [11:0] {
        CsrMstatus   = 12'h300,
        CsrMisa      = 12'h301,
        CsrMtvec     = 12'h305,
        CsrMscratch  = 12'h340,
        CsrMepc      = 12'h341,
        CsrMcause    = 12'h342,
        CsrMtval     = 12'h343,
        CsrMcycle    = 12'hB00,
        CsrMinstret  = 12'hB02,
        CsrMcycleh   = 12'hB80,
        CsrMinstreth = 12'hB82,
        CsrCycle     = 12'hC00,
        CsrInstret   = 12'hC02,
        CsrCycleh    = 12'hC80,
        CsrInstreth  = 12'hC82,
        CsrMhartid   = 12'hF14
    } csr_addr_t;

    localparam int unsigned MSTATUS_MIE_BIT  = 3;
    localparam int unsigned MSTATUS_MPIE_BIT = 7;

    localparam logic [31:0] MISA_VALUE = 32'h4000_0100;

endpackage

// File: rtl/csr_file_counter64.sv
// 64-bit free-running counter with independent low/high word writes.
// A word write in a cycle suppresses that cycle's increment.
module csr_counter64 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic [31:0] wdata_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata_hi,
    output logic [63:0] count
);

    logic [63:0] count_q;
    logic [63:0] count_d;

    always_comb begin
        count_d = count_q;
        if (wr_lo || wr_hi) begin
            if (wr_lo) count_d[31:0]  = wdata_lo;
            if (wr_hi) count_d[63:32] = wdata_hi;
        end else if (inc) begin
            count_d = count_q + 64'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 64'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: trap entry/mret sequencing, counters and combinational read mux.
module csr_file
    import csr_file_pkg::*;
#(
    parameter logic [31:0] HART_ID     = 32'd0,
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] csr_addr,
    output logic [31:0] csr_data,
    output logic        csr_illegal,
    input  logic        csr_wb_en,
    input  logic [31:0] csr_next,
    input  logic        trap_req,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_tval,
    input  logic        mret,
    input  logic        instr_retire,
    output logic [31:0] mepc,
    output logic [31:0] trap_vector
);

    logic        mie_q, mpie_q;
    logic [31:0] mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
    logic [63:0] mcycle, minstret;
    logic        implemented, read_only, wr_ok;

    assign read_only = (csr_addr[11:10] == 2'b11);
    // Lower-priority events are dropped when a trap or mret retires this cycle.
    assign wr_ok = csr_wb_en && !trap_req && !mret && implemented && !read_only;

    always_comb begin
        csr_data    = 32'd0;
        implemented = 1'b1;
        case (csr_addr)
            CsrMstatus: begin
                csr_data                   = 32'h0000_1800;
                csr_data[MSTATUS_MIE_BIT]  = mie_q;
                csr_data[MSTATUS_MPIE_BIT] = mpie_q;
            end
            CsrMisa:                 csr_data = MISA_VALUE;
            CsrMtvec:                csr_data = mtvec_q;
            CsrMscratch:             csr_data = mscratch_q;
            CsrMepc:                 csr_data = mepc_q;
            CsrMcause:               csr_data = mcause_q;
            CsrMtval:                csr_data = mtval_q;
            CsrMcycle, CsrCycle:     csr_data = mcycle[31:0];
            CsrMcycleh, CsrCycleh:   csr_data = mcycle[63:32];
            CsrMinstret, CsrInstret: csr_data = minstret[31:0];
            CsrMinstreth, CsrInstreth: csr_data = minstret[63:32];
            CsrMhartid:              csr_data = HART_ID;
            default:                 implemented = 1'b0;
        endcase
    end

    assign csr_illegal = !implemented || (csr_wb_en && read_only);
    assign mepc        = mepc_q;
    assign trap_vector = {mtvec_q[31:2], 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtvec_q    <= RESET_MTVEC;
            mscratch_q <= 32'd0;
            mepc_q     <= 32'd0;
            mcause_q   <= 32'd0;
            mtval_q    <= 32'd0;
        end else if (trap_req) begin
            mepc_q   <= {trap_pc[31:2], 2'b00};
            mcause_q <= trap_cause;
            mtval_q  <= trap_tval;
            mpie_q   <= mie_q;
            mie_q    <= 1'b0;
        end else if (mret) begin
            mie_q  <= mpie_q;
            mpie_q <= 1'b1;
        end else if (wr_ok) begin
            case (csr_addr)
                CsrMstatus: begin
                    mie_q  <= csr_next[MSTATUS_MIE_BIT];
                    mpie_q <= csr_next[MSTATUS_MPIE_BIT];
                end
                CsrMtvec:    mtvec_q    <= {csr_next[31:2], 2'b00};
                CsrMscratch: mscratch_q <= csr_next;
                CsrMepc:     mepc_q     <= {csr_next[31:2], 2'b00};
                CsrMcause:   mcause_q   <= csr_next;
                CsrMtval:    mtval_q    <= csr_next;
                default:     ;
            endcase
        end
    end

    csr_counter64 u_mcycle (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (1'b1),
        .wr_lo    (wr_ok && (csr_addr == CsrMcycle)),
        .wdata_lo (csr_next),
        .wr_hi    (wr_ok && (csr_addr == CsrMcycleh)),
        .wdata_hi (csr_next),
        .count    (mcycle)
    );

    csr_counter64 u_minstret (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (instr_retire && !trap_req),
        .wr_lo    (wr_ok && (csr_addr == CsrMinstret)),
        .wdata_lo (csr_next),
        .wr_hi    (wr_ok && (csr_addr == CsrMinstreth)),
        .wdata_hi (csr_next),
        .count    (minstret)
    );

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: expectations queued at stimulus time, popped at sample time.
module tb_csr_file;

    localparam logic [31:0] HART_ID     = 32'd3;
    localparam logic [31:0] RESET_MTVEC = 32'h0000_1003;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] csr_addr = 12'h000;
    logic [31:0] csr_data;
    logic        csr_illegal;
    logic        csr_wb_en = 1'b0;
    logic [31:0] csr_next = 32'd0;
    logic        trap_req = 1'b0;
    logic [31:0] trap_cause = 32'd0;
    logic [31:0] trap_pc = 32'd0;
    logic [31:0] trap_tval = 32'd0;
    logic        mret = 1'b0;
    logic        instr_retire = 1'b0;
    logic [31:0] mepc;
    logic [31:0] trap_vector;

    csr_file #(
        .HART_ID     (HART_ID),
        .RESET_MTVEC (RESET_MTVEC)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .csr_addr     (csr_addr),
        .csr_data     (csr_data),
        .csr_illegal  (csr_illegal),
        .csr_wb_en    (csr_wb_en),
        .csr_next     (csr_next),
        .trap_req     (trap_req),
        .trap_cause   (trap_cause),
        .trap_pc      (trap_pc),
        .trap_tval    (trap_tval),
        .mret         (mret),
        .instr_retire (instr_retire),
        .mepc         (mepc),
        .trap_vector  (trap_vector)
    );

    always #5 clk = ~clk;

    typedef enum int {SelData, SelIllegal, SelMepc, SelVector} sel_e;
    typedef struct {
        string       tag;
        sel_e        sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_failed = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_failed++;
            $display("FAIL %s: got %08h, expected %08h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input sel_e sel, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.sel)
                SelData:    obs = csr_data;
                SelIllegal: obs = {31'd0, csr_illegal};
                SelMepc:    obs = mepc;
                default:    obs = trap_vector;
            endcase
            check_eq(e.tag, obs, e.exp);
        end
    endtask

    // Inputs change 1ns after the rising edge; reads settle 2ns later, far from the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [11:0] addr, input logic [31:0] exp_data,
                      input logic exp_ill);
        csr_addr = addr;
        push(tag, SelData, exp_data);
        push({tag, "_ill"}, SelIllegal, {31'd0, exp_ill});
        #2;
        drain();
    endtask

    task automatic wr(input logic [11:0] addr, input logic [31:0] data);
        csr_addr  = addr;
        csr_next  = data;
        csr_wb_en = 1'b1;
        tick();
        csr_wb_en = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();

        push("rst_mepc", SelMepc, 32'd0);
        push("rst_vector", SelVector, 32'h0000_1000);
        rd("rst_mtvec", 12'h305, RESET_MTVEC, 1'b0);
        rd("hartid", 12'hF14, HART_ID, 1'b0);
        rd("misa", 12'h301, 32'h4000_0100, 1'b0);
        rd("rst_mstatus", 12'h300, 32'h0000_1800, 1'b0);

        wr(12'h341, 32'h8000_0103);
        push("mepc_wr", SelMepc, 32'h8000_0100);
        rd("unimpl", 12'h7C0, 32'd0, 1'b1);

        wr(12'h305, 32'h0000_2007);
        push("vector_wr", SelVector, 32'h0000_2004);
        rd("mtvec_wr", 12'h305, 32'h0000_2004, 1'b0);

        // Trap in the same cycle as a mscratch write: the write must be dropped.
        wr(12'h300, 32'h0000_0008);
        rd("mie_set", 12'h300, 32'h0000_1808, 1'b0);
        trap_req   = 1'b1;
        trap_cause = 32'h2;
        trap_pc    = 32'h0000_0107;
        trap_tval  = 32'h0000_0055;
        csr_addr   = 12'h340;
        csr_next   = 32'hDEAD_BEEF;
        csr_wb_en  = 1'b1;
        tick();
        trap_req  = 1'b0;
        csr_wb_en = 1'b0;
        push("trap_mepc", SelMepc, 32'h0000_0104);
        rd("trap_mcause", 12'h342, 32'h2, 1'b0);
        rd("trap_mtval", 12'h343, 32'h55, 1'b0);
        rd("trap_mstatus", 12'h300, 32'h0000_1880, 1'b0);
        rd("trap_wr_drop", 12'h340, 32'd0, 1'b0);

        mret      = 1'b1;
        csr_addr  = 12'h340;
        csr_next  = 32'h1234_5678;
        csr_wb_en = 1'b1;
        tick();
        mret      = 1'b0;
        csr_wb_en = 1'b0;
        rd("mret_mstatus", 12'h300, 32'h0000_1888, 1'b0);
        rd("mret_wr_drop", 12'h340, 32'd0, 1'b0);
        wr(12'h340, 32'h1234_5678);
        rd("mscratch", 12'h340, 32'h1234_5678, 1'b0);

        // Low-word rollover carries into the high word on the same edge.
        wr(12'hB00, 32'hFFFF_FFFE);
        tick();
        tick();
        rd("mcycle_lo_wrap", 12'hB00, 32'd0, 1'b0);
        rd("mcycle_hi_carry", 12'hB80, 32'd1, 1'b0);
        csr_addr  = 12'hC00;
        csr_next  = 32'd0;
        csr_wb_en = 1'b1;
        push("ro_write_ill", SelIllegal, 32'd1);
        #2;
        drain();
        tick();
        csr_wb_en = 1'b0;
        rd("cycle_after_ro", 12'hC00, 32'd1, 1'b0);
        rd("cycleh_after_ro", 12'hC80, 32'd1, 1'b0);

        // Retire 5 instructions with a trap on the 3rd: only 4 count.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            instr_retire = 1'b1;
            trap_req     = (i == 2);
            tick();
        end
        trap_req     = 1'b0;
        instr_retire = 1'b0;
        rd("minstret", 12'hB02, 32'd4, 1'b0);
        rd("minstreth", 12'hB82, 32'd0, 1'b0);
        rd("instret", 12'hC02, 32'd4, 1'b0);

        // Asynchronous reset mid-cycle clears counters without a clock edge.
        instr_retire = 1'b1;
        tick();
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        rd("arst_mcycle", 12'hB00, 32'd0, 1'b0);
        rd("arst_mcycleh", 12'hB80, 32'd0, 1'b0);
        rd("arst_minstret", 12'hB02, 32'd0, 1'b0);
        rd("arst_mscratch", 12'h340, 32'd0, 1'b0);
        push("arst_vector", SelVector, 32'h0000_1000);
        drain();
        instr_retire = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
